load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32'h257, the number of words in data_memory; valid word indices are 0..MEM_WORDS-1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port req, input, 1, a memory-stage request valid.
REQ-005 SHALL have port we, input, 1, which selects store when 1 and load when 0.
REQ-006 SHALL have port size, input, 2, the access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port unsigned_ld, input, 1, which selects zero-extension for loads when 1 and sign-extension when 0.
REQ-008 SHALL have port addr, input, 32, the byte address.
REQ-009 SHALL have port wdata, input, 32, the store data, right-justified.
REQ-010 SHALL have port ready, output, 1, which is high when a request can be accepted this cycle.
REQ-011 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port rdata, output, 32, the extended load result, valid while done=1.
REQ-013 SHALL have port err, output, 1, which flags a misaligned, illegal-size or out-of-range access and is valid while done=1.
REQ-014 SHALL have the following ports to data_memory:
- dm_address, output, 32, the word index addr[31:2];
- dm_write_data, output, 32;
- dm_mem_write, output, 1;
- dm_mem_read, output, 1;
- dm_read_data, input, 32, a combinational read of word dm_address.

Function
REQ-015 SHALL use byte ordering big-endian: addr[1:0]=0 maps to bits 31:24 and addr[1:0]=3 maps to bits 7:0; a halfword at addr[1]=0 maps to bits 31:16.
REQ-016 SHALL implement a state machine with states IDLE and MERGE; ready SHALL be 1 iff state==IDLE and reset==0.
REQ-017 SHALL accept a request when req & ready; req SHALL be ignored when ready=0, and the requester holds it.
REQ-018 SHALL flag a request as illegal when size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0, or addr[31:2]>=MEM_WORDS.
- An illegal request SHALL make no memory access.
- It SHALL produce done=1, err=1, rdata=0 in the next cycle.
REQ-019 Load, accepted in cycle N: SHALL drive dm_mem_read=1 in cycle N and register the selected lane extended per unsigned_ld; done=1 and rdata valid in N+1; the state remains IDLE.
REQ-020 Word store, accepted in N: SHALL drive dm_mem_write=1 and dm_write_data=wdata in N; done=1 in N+1; the state remains IDLE.
REQ-021 Byte/halfword store, accepted in N:
- Cycle N: dm_mem_read=1; the unit captures dm_read_data, the address, the size and the lane data; the state goes to MERGE.
- Cycle N+1 (MERGE): dm_mem_write=1 with the captured word, whose target lane is replaced by wdata[7:0] or wdata[15:0] and whose other lanes are unchanged; dm_address equals the captured index; the state goes to IDLE.
- Cycle N+2: done=1.
REQ-022 SHALL sustain back-to-back throughput of one load or word store per cycle; a request accepted in the same cycle done is high SHALL be legal.
REQ-023 A load accepted the cycle after a store completes its write SHALL return the updated data, with no forwarding required.
REQ-024 SHALL hold dm_mem_write and dm_mem_read at 0 whenever no access is being performed, and SHALL force them to 0 when reset=1, including combinationally within the reset cycle.
REQ-025 SHALL keep done high for exactly one cycle per accepted request; rdata and err SHALL hold their value until the next done.

Reset
REQ-026 When reset=1 at a rising edge, the unit SHALL set state=IDLE, done=0, rdata=0, err=0; ready SHALL be 0 during reset.
REQ-027 Reset asserted while in MERGE SHALL abort the store: no write reaches memory and no done is produced.

Verification
REQ-028 SHALL pass the byte-load scenario: word 2 preloaded with 0x8899AABB; lb addr 0x9 -> done next cycle with rdata=0xFFFFFF99, err=0; lbu addr 0x9 -> rdata=0x00000099.
REQ-029 SHALL pass the halfword-load scenario: lh addr 0xA -> rdata=0xFFFFAABB; lhu addr 0x8 -> rdata=0x00008899.
REQ-030 SHALL pass the sub-word store scenario: sb addr 0xB, wdata=0x12 -> ready=0 for one cycle, done two cycles after accept, word 2 becomes 0x8899AA12; then sh addr 0x8, wdata=0x3344 -> word 2 becomes 0x3344AA12.
REQ-031 SHALL pass the back-to-back scenario: sw addr 0x10, wdata=0xDEADBEEF, then lw addr 0x10 in the following cycle -> rdata=0xDEADBEEF, with done asserted on consecutive cycles.
REQ-032 SHALL pass the error scenario: lw addr 0x6, sh addr 0x5, size=11, and lw addr (MEM_WORDS<<2) -> each gives err=1 and rdata=0, with dm_mem_write=0 throughout.
REQ-033 SHALL pass the reset-abort scenario: sb addr 0x8, wdata=0x55 with reset asserted in the MERGE cycle -> word 2 unchanged, done=0, ready=1 after reset is released.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - big-endian load/store unit with read-merge-write sub-word stores
module load_store_unit #(
    parameter logic [31:0] MEM_WORDS = 32'h257
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] dm_address,
    output logic [31:0] dm_write_data,
    output logic        dm_mem_write,
    output logic        dm_mem_read,
    input  logic [31:0] dm_read_data
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] MERGE = 1'b1;

    logic [0:0]  state;
    logic [29:0] cap_idx;
    logic [1:0]  cap_off;
    logic        cap_half;
    logic [31:0] cap_word;
    logic [15:0] cap_data;

    logic        accept;
    logic        illegal;
    logic        word_store;
    logic [4:0]  ld_shamt;
    logic [31:0] ld_lane;
    logic [31:0] ld_ext;
    logic [4:0]  st_shamt;
    logic [31:0] st_mask;
    logic [31:0] st_lane;
    logic [31:0] merged;

    assign ready      = (state == IDLE) && !reset;
    assign accept     = req && ready;
    assign word_store = we && (size == 2'b10);

    always_comb begin
        illegal = 1'b0;
        if (size == 2'b11)
            illegal = 1'b1;
        if (size == 2'b01 && addr[0])
            illegal = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;
        if ({2'b00, addr[31:2]} >= MEM_WORDS)
            illegal = 1'b1;
    end

    // Big-endian: lane offset k sits (3-k) bytes above bit 0, so shift by ~k bytes.
    always_comb begin
        case (size)
            2'b00:   ld_shamt = {~addr[1:0], 3'b000};
            2'b01:   ld_shamt = {~addr[1], 4'b0000};
            default: ld_shamt = 5'd0;
        endcase
        ld_lane = dm_read_data >> ld_shamt;
        case (size)
            2'b00:   ld_ext = unsigned_ld ? {24'h0, ld_lane[7:0]}
                                          : {{24{ld_lane[7]}}, ld_lane[7:0]};
            2'b01:   ld_ext = unsigned_ld ? {16'h0, ld_lane[15:0]}
                                          : {{16{ld_lane[15]}}, ld_lane[15:0]};
            default: ld_ext = ld_lane;
        endcase
    end

    always_comb begin
        if (cap_half) begin
            st_shamt = {~cap_off[1], 4'b0000};
            st_mask  = 32'h0000_FFFF << st_shamt;
            st_lane  = {16'h0, cap_data} << st_shamt;
        end else begin
            st_shamt = {~cap_off, 3'b000};
            st_mask  = 32'h0000_00FF << st_shamt;
            st_lane  = {24'h0, cap_data[7:0]} << st_shamt;
        end
        merged = (cap_word & ~st_mask) | (st_lane & st_mask);
    end

    // Strobes are gated by reset directly so an aborted merge never reaches memory.
    always_comb begin
        dm_address    = {2'b00, addr[31:2]};
        dm_write_data = wdata;
        dm_mem_write  = 1'b0;
        dm_mem_read   = 1'b0;
        if (!reset) begin
            if (state == MERGE) begin
                dm_address    = {2'b00, cap_idx};
                dm_write_data = merged;
                dm_mem_write  = 1'b1;
            end else if (accept && !illegal) begin
                if (word_store)
                    dm_mem_write = 1'b1;
                else
                    dm_mem_read  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            rdata <= 32'h0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == MERGE) begin
                state <= IDLE;
                done  <= 1'b1;
                rdata <= 32'h0;
                err   <= 1'b0;
            end else if (accept) begin
                if (illegal) begin
                    done  <= 1'b1;
                    rdata <= 32'h0;
                    err   <= 1'b1;
                end else if (!we) begin
                    done  <= 1'b1;
                    rdata <= ld_ext;
                    err   <= 1'b0;
                end else if (word_store) begin
                    done  <= 1'b1;
                    rdata <= 32'h0;
                    err   <= 1'b0;
                end else begin
                    state    <= MERGE;
                    cap_idx  <= addr[31:2];
                    cap_off  <= addr[1:0];
                    cap_half <= size[0];
                    cap_word <= dm_read_data;
                    cap_data <= wdata[15:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam logic [31:0] MEM_WORDS = 32'h257;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic        dm_mem_write;
    logic        dm_mem_read;
    logic [31:0] dm_read_data;

    logic        preload;
    logic [31:0] mem [0:MEM_WORDS-1];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_count = 0;
    int          rd_count = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .we           (we),
        .size         (size),
        .unsigned_ld  (unsigned_ld),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .done         (done),
        .rdata        (rdata),
        .err          (err),
        .dm_address   (dm_address),
        .dm_write_data(dm_write_data),
        .dm_mem_write (dm_mem_write),
        .dm_mem_read  (dm_mem_read),
        .dm_read_data (dm_read_data)
    );

    always #5 clk = ~clk;

    assign dm_read_data = (dm_address < MEM_WORDS) ? mem[dm_address[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            mem[2]           <= 32'h8899AABB;
            mem[MEM_WORDS-1] <= 32'h01234567;
        end else begin
            if (dm_mem_write) begin
                mem[dm_address[9:0]] <= dm_write_data;
                wr_count++;
            end
            if (dm_mem_read)
                rd_count++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        logic exp_wr;
        logic exp_rd;
        exp_wr = !exp_err && w && (sz == 2'b10);
        exp_rd = !exp_err && !(w && (sz == 2'b10));
        @(negedge clk);
        check_val({tag, ".idle_done"}, {31'h0, done}, 32'h0);
        we = w; size = sz; unsigned_ld = u; addr = a; wdata = d; req = 1'b1;
        #1;
        check_val({tag, ".ready"}, {31'h0, ready}, 32'h1);
        check_val({tag, ".rd"}, {31'h0, dm_mem_read}, {31'h0, exp_rd});
        check_val({tag, ".wr"}, {31'h0, dm_mem_write}, {31'h0, exp_wr});
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check_val({tag, ".merge_done"}, {31'h0, done}, 32'h0);
            check_val({tag, ".merge_ready"}, {31'h0, ready}, 32'h0);
            check_val({tag, ".merge_wr"}, {31'h0, dm_mem_write}, 32'h1);
            check_val({tag, ".merge_addr"}, dm_address, a >> 2);
        end
        @(negedge clk);
        check_val({tag, ".done"}, {31'h0, done}, 32'h1);
        check_val({tag, ".rdata"}, rdata, exp_rdata);
        check_val({tag, ".err"}, {31'h0, err}, {31'h0, exp_err});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int r0;
        reset = 1'b1; preload = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00;
        unsigned_ld = 1'b0; addr = 32'h0; wdata = 32'h0;

        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h1;
        #1;
        check_val("rst.ready", {31'h0, ready}, 32'h0);
        check_val("rst.wr", {31'h0, dm_mem_write}, 32'h0);
        check_val("rst.rd", {31'h0, dm_mem_read}, 32'h0);
        @(negedge clk);
        check_val("rst.done", {31'h0, done}, 32'h0);
        check_val("rst.rdata", rdata, 32'h0);
        check_val("rst.err", {31'h0, err}, 32'h0);
        req = 1'b0; preload = 1'b0; reset = 1'b0;

        run_op("lb9",   1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'hFFFFFF99, 1'b0, 1);
        run_op("lbu9",  1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 32'h00000099, 1'b0, 1);
        run_op("lbB",   1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'hFFFFFFBB, 1'b0, 1);
        run_op("lbu8",  1'b0, 2'b00, 1'b1, 32'h8, 32'h0, 32'h00000088, 1'b0, 1);
        run_op("lhA",   1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'hFFFFAABB, 1'b0, 1);
        run_op("lhu8",  1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 32'h00008899, 1'b0, 1);
        run_op("lw8",   1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h8899AABB, 1'b0, 1);

        run_op("sbB", 1'b1, 2'b00, 1'b0, 32'hB, 32'h12, 32'h0, 1'b0, 2);
        check_val("sbB.mem", mem[2], 32'h8899AA12);
        run_op("sh8", 1'b1, 2'b01, 1'b0, 32'h8, 32'h3344, 32'h0, 1'b0, 2);
        check_val("sh8.mem", mem[2], 32'h3344AA12);

        @(negedge clk);
        we = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h10; wdata = 32'hDEADBEEF; req = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
        @(negedge clk);
        check_val("b2b.sw_done", {31'h0, done}, 32'h1);
        check_val("b2b.sw_err", {31'h0, err}, 32'h0);
        check_val("b2b.ld_ready", {31'h0, ready}, 32'h1);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check_val("b2b.lw_done", {31'h0, done}, 32'h1);
        check_val("b2b.lw_rdata", rdata, 32'hDEADBEEF);
        check_val("b2b.mem", mem[4], 32'hDEADBEEF);

        w0 = wr_count; r0 = rd_count;
        run_op("err_lw6", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1);
        run_op("err_sh5", 1'b1, 2'b01, 1'b0, 32'h5, 32'h77, 32'h0, 1'b1, 1);
        run_op("err_sz3", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        run_op("err_oor", 1'b0, 2'b10, 1'b0, MEM_WORDS << 2, 32'h0, 32'h0, 1'b1, 1);
        check_val("err.no_write", wr_count, w0);
        check_val("err.no_read", rd_count, r0);
        run_op("lw_last", 1'b0, 2'b10, 1'b0, (MEM_WORDS - 1) << 2, 32'h0, 32'h01234567, 1'b0, 1);

        w0 = wr_count;
        @(negedge clk);
        we = 1'b1; size = 2'b00; addr = 32'h8; wdata = 32'h55; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0; reset = 1'b1;
        #1;
        check_val("abort.wr", {31'h0, dm_mem_write}, 32'h0);
        check_val("abort.ready", {31'h0, ready}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("abort.done", {31'h0, done}, 32'h0);
        check_val("abort.ready_after", {31'h0, ready}, 32'h1);
        check_val("abort.mem", mem[2], 32'h3344AA12);
        check_val("abort.no_write", wr_count, w0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
